regread_scoreboard: RTL

REGREAD_SCOREBOARD -- requirements
Module: regread_scoreboard

---
 rtl/regread_scoreboard_pkg.sv | 37 +++
 rtl/regread_scoreboard_regfile.sv | 55 +++++
 rtl/regread_scoreboard.sv | 128 ++++++++++++
 3 files changed

// File: rtl/regread_scoreboard_pkg.sv
// Shared definitions for the register-read / scoreboard slice.
//
// Purpose:
//   Holds the default datapath sizes and the instruction-type codes that the
//   decode stage uses to work out which source ports an instruction reads.
//   The source-used mask itself is built outside the scoreboard block. The
//   src_mask helper is provided here so decode and test code share one table.
//
// Contents:
//   XLEN_DEF, NREG_DEF, NRD_DEF  default parameter values
//   instr_type_e                 instruction format codes
//   src_mask()                   format -> two-port source-used mask
package regread_scoreboard_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int NRD_DEF  = 2;

    typedef enum logic [2:0] {
        TYPER = 3'd0,
        TYPEI = 3'd1,
        TYPES = 3'd2,
        TYPEB = 3'd3,
        TYPEU = 3'd4,
        TYPEJ = 3'd5
    } instr_type_e;

    // R, S and B formats read two sources, I reads only rs1, U and J read none.
    function automatic logic [1:0] src_mask(input instr_type_e t);
        case (t)
            TYPER, TYPES, TYPEB: return 2'b11;
            TYPEI:               return 2'b01;
            default:             return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/regread_scoreboard_regfile.sv
// regfile_array: architectural register storage.
//
// Purpose:
//   NREG x XLEN register array with NRD asynchronous read ports and one
//   synchronous write port. Register 0 is hardwired to zero. Writes to
//   index 0 are dropped, and reads of index 0 always return 0.
//
// Ports:
//   clk_i    in   rising-edge clock for the write port
//   rst_i    in   asynchronous active-high reset, clears every register
//   we_i     in   write enable
//   waddr_i  in   AW-bit write index
//   wdata_i  in   XLEN-bit write data
//   raddr_i  in   NRD*AW packed read indices, port k at [k*AW +: AW]
//   rdata_o  out  NRD*XLEN packed read data, port k at [k*XLEN +: XLEN]
module regfile_array
    import regread_scoreboard_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRD  = NRD_DEF,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                we_i,
    input  logic [AW-1:0]       waddr_i,
    input  logic [XLEN-1:0]     wdata_i,
    input  logic [NRD*AW-1:0]   raddr_i,
    output logic [NRD*XLEN-1:0] rdata_o
);

    logic [XLEN-1:0] regs_q [NREG];

    // Single write port. Index 0 is never written, so its storage stays at the
    // reset value. The read side also forces it to zero, so that location
    // never affects results.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Asynchronous read ports, with x0 forced to zero.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = raddr_i[k*AW +: AW];
        assign rdata_o[k*XLEN +: XLEN] = (ra == '0) ? '0 : regs_q[ra];
    end

endmodule

// File: rtl/regread_scoreboard.sv
// regread_scoreboard: operand read with write-through bypass plus a
// pending-write scoreboard that stalls issue on RAW and WAW hazards.
//
// Purpose:
//   Reads the source operands of the instruction in decode in the same
//   cycle. A writeback that lands in that cycle is forwarded to the
//   operands. One busy bit per register tracks destinations that have been
//   issued but not yet written back. Issue stalls while a used source or
//   the destination is still pending.
//
// Ports:
//   clk_i          in   clock
//   rst_i          in   asynchronous active-high reset
//   issue_valid_i  in   an instruction is presented for issue
//   src_valid_i    in   NRD per-port source-used mask
//   rs_i           in   NRD*AW packed source indices
//   rd_we_i        in   instruction writes a destination
//   rd_i           in   destination index
//   wb_valid_i     in   writeback strobe
//   wb_rd_i        in   writeback index
//   wb_data_i      in   writeback data
//   val_o          out  NRD*XLEN packed operand values
//   stall_o        out  issue blocked by a hazard
//   busy_o         out  NREG pending-write bits (bit 0 always 0)
module regread_scoreboard
    import regread_scoreboard_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRD  = NRD_DEF,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                issue_valid_i,
    input  logic [NRD-1:0]      src_valid_i,
    input  logic [NRD*AW-1:0]   rs_i,
    input  logic                rd_we_i,
    input  logic [AW-1:0]       rd_i,
    input  logic                wb_valid_i,
    input  logic [AW-1:0]       wb_rd_i,
    input  logic [XLEN-1:0]     wb_data_i,
    output logic [NRD*XLEN-1:0] val_o,
    output logic                stall_o,
    output logic [NREG-1:0]     busy_o
);

    logic [NREG-1:0]     busy_q;
    logic [NREG-1:0]     busy_d;
    logic [NREG-1:0]     wb_clr;
    logic [NREG-1:0]     eff_busy;
    logic [NRD*XLEN-1:0] rf_rdata;
    logic [NRD-1:0]      raw_hit;
    logic                waw_hit;
    logic                issue_ok;
    logic                rf_we;

    assign rf_we = wb_valid_i && (wb_rd_i != '0);

    regfile_array #(
        .XLEN (XLEN),
        .NREG (NREG),
        .NRD  (NRD)
    ) u_regfile (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (rf_we),
        .waddr_i (wb_rd_i),
        .wdata_i (wb_data_i),
        .raddr_i (rs_i),
        .rdata_o (rf_rdata)
    );

    // One-hot mask of the register being written back this cycle. A
    // writeback resolves the hazard in the same cycle, so this mask is removed
    // from the busy vector before any hazard check.
    always_comb begin
        wb_clr = '0;
        if (wb_valid_i) begin
            wb_clr[wb_rd_i] = 1'b1;
        end
    end

    assign eff_busy = busy_q & ~wb_clr;

    // Per-port operand select and RAW detection. When the source matches the
    // register being written back, the writeback data is forwarded. Because rs
    // is nonzero here, the match also excludes a writeback to x0.
    for (genvar k = 0; k < NRD; k++) begin : g_port
        logic [AW-1:0] rs;
        logic          used;
        assign rs   = rs_i[k*AW +: AW];
        assign used = src_valid_i[k] && (rs != '0);
        assign raw_hit[k] = used && eff_busy[rs];
        assign val_o[k*XLEN +: XLEN] =
            !used                            ? '0        :
            (wb_valid_i && (wb_rd_i == rs))  ? wb_data_i :
                                               rf_rdata[k*XLEN +: XLEN];
    end

    assign waw_hit  = rd_we_i && (rd_i != '0) && eff_busy[rd_i];
    assign stall_o  = issue_valid_i && ((|raw_hit) || waw_hit);
    assign issue_ok = issue_valid_i && !stall_o;

    // Next busy state. The writeback clear is applied first and the new
    // issue is set afterwards, so a new issue to the same index as the
    // writeback leaves the bit set. Bit 0 is held at zero.
    always_comb begin
        busy_d = busy_q & ~wb_clr;
        if (issue_ok && rd_we_i && (rd_i != '0)) begin
            busy_d[rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard register. The asynchronous clear also drops stall_o right
    // away, because stall_o is derived only from these bits.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule
